// File: rtl/apb_slave_if.sv
// APB bus bundle between an APB master and the I2C-APB slave front end.
// Signal names follow the APB bus naming used by the rest of the I2C-APB interface.
interface apb_slave_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();
  logic              PSELx;
  logic              PWRITE;
  logic              PENABLE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;

  modport master (
    output PSELx, PWRITE, PENABLE, PADDR, PWDATA,
    input  PREADY, PRDATA
  );

  modport slave (
    input  PSELx, PWRITE, PENABLE, PADDR, PWDATA,
    output PREADY, PRDATA
  );
endinterface

// File: rtl/apb_slave.sv
// APB slave front end of the I2C-APB interface: DATA pushes TX / pops RX, plus CTRL/SADDR/PRESC/STATUS.
// Optional macro APB_WAIT_STATE_EN: FIFO full/empty inserts wait states instead of dropping the access.
module apb_slave #(
  parameter int              ADDR_W   = 8,
  parameter int              DATA_W   = 8,
  parameter logic [DATA_W-1:0] CTRL_RST = '0
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_slave_if.slave        apb,
  input  logic [DATA_W-1:0] APB_RX,
  input  logic              WRITE_FULL,
  input  logic              READ_EMPTY,
  output logic              R_ENA,
  output logic              W_ENA,
  output logic [DATA_W-1:0] APB_TX
);

  localparam logic [ADDR_W-1:0] ADDR_DATA   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_SADDR  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_PRESC  = ADDR_W'(4);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] ctrl_q;
  logic [DATA_W-1:0] saddr_q;
  logic [DATA_W-1:0] presc_q;

  logic acc;
  logic data_sel;
  logic data_wr;
  logic data_rd;
  logic stall;
  logic ready;
  logic wr_commit;
  logic [DATA_W-1:0] rd_data;

  // A PENABLE seen while IDLE never qualifies: a transfer must pass through SETUP first.
  assign acc      = apb.PSELx & apb.PENABLE & ((state == SETUP) | (state == ACCESS));
  assign data_sel = (apb.PADDR == ADDR_DATA);
  assign data_wr  = acc & apb.PWRITE & data_sel;
  assign data_rd  = acc & ~apb.PWRITE & data_sel;

`ifdef APB_WAIT_STATE_EN
  assign stall = (data_wr & WRITE_FULL) | (data_rd & READ_EMPTY);
`else
  assign stall = 1'b0;
`endif

  assign ready      = acc & ~stall;
  assign apb.PREADY = ready;
  assign wr_commit  = acc & apb.PWRITE & ready;

  // Strobes fire only on the completing cycle, so each transfer pushes/pops at most once.
  assign W_ENA  = data_wr & ~WRITE_FULL;
  assign R_ENA  = data_rd & ~READ_EMPTY;
  assign APB_TX = W_ENA ? apb.PWDATA : tx_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_data = '0;
    if (acc && !apb.PWRITE && ready) begin
      case (apb.PADDR)
        ADDR_DATA:   rd_data = R_ENA ? APB_RX : '0;
        ADDR_STATUS: rd_data = DATA_W'({READ_EMPTY, WRITE_FULL});
        ADDR_CTRL:   rd_data = ctrl_q;
        ADDR_SADDR:  rd_data = saddr_q;
        ADDR_PRESC:  rd_data = presc_q;
        default:     rd_data = '0;
      endcase
    end
  end

  assign apb.PRDATA = rd_data;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else if (!apb.PSELx) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (!apb.PENABLE) state <= SETUP;
        SETUP:   if (apb.PENABLE) state <= ACCESS;
        ACCESS:  if (ready) state <= apb.PENABLE ? IDLE : SETUP;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_q    <= '0;
      ctrl_q  <= CTRL_RST;
      saddr_q <= '0;
      presc_q <= '0;
    end else begin
      if (W_ENA) tx_q <= apb.PWDATA;
      if (wr_commit) begin
        case (apb.PADDR)
          ADDR_CTRL:  ctrl_q  <= apb.PWDATA;
          ADDR_SADDR: saddr_q <= apb.PWDATA;
          ADDR_PRESC: presc_q <= apb.PWDATA;
          default:    ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_slave.sv
// Self-checking bench for apb_slave: scoreboard of expected completions, one task per scenario.
// Expectations for blocked FIFO accesses follow APB_WAIT_STATE_EN when it is defined.
module tb_apb_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] APB_RX;
  logic       WRITE_FULL;
  logic       READ_EMPTY;
  logic       R_ENA;
  logic       W_ENA;
  logic [7:0] APB_TX;

  int checks = 0;
  int errors = 0;

  apb_slave_if #(.ADDR_W(8), .DATA_W(8)) apb ();

  apb_slave #(.ADDR_W(8), .DATA_W(8), .CTRL_RST(8'h00)) dut (
    .PCLK       (clk),
    .PRESETn    (rst_n),
    .apb        (apb),
    .APB_RX     (APB_RX),
    .WRITE_FULL (WRITE_FULL),
    .READ_EMPTY (READ_EMPTY),
    .R_ENA      (R_ENA),
    .W_ENA      (W_ENA),
    .APB_TX     (APB_TX)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] prdata;
    logic       w_ena;
    logic       r_ena;
    logic [7:0] tx;
  } exp_t;

  exp_t sb_q[$];

  // Reference model of the register file and the held TX byte.
  logic [7:0] m_ctrl, m_saddr, m_presc, tx_hold;

  function automatic exp_t predict(input string name, input logic wr,
                                   input logic [7:0] addr, input logic [7:0] wdata);
    exp_t e;
    e.name = name; e.prdata = 8'h00; e.w_ena = 1'b0; e.r_ena = 1'b0; e.tx = tx_hold;
    if (wr) begin
      if (addr == 8'h00 && !WRITE_FULL) begin e.w_ena = 1'b1; e.tx = wdata; end
    end else begin
      case (addr)
        8'h00: if (!READ_EMPTY) begin e.r_ena = 1'b1; e.prdata = APB_RX; end
        8'h01: e.prdata = {6'b0, READ_EMPTY, WRITE_FULL};
        8'h02: e.prdata = m_ctrl;
        8'h03: e.prdata = m_saddr;
        8'h04: e.prdata = m_presc;
        default: e.prdata = 8'h00;
      endcase
    end
    return e;
  endfunction

  task automatic model_commit(input logic wr, input logic [7:0] addr,
                              input logic [7:0] wdata, input logic pushed);
    if (wr) begin
      case (addr)
        8'h02: m_ctrl  = wdata;
        8'h03: m_saddr = wdata;
        8'h04: m_presc = wdata;
        default: ;
      endcase
    end
    if (pushed) tx_hold = wdata;
  endtask

  // Pops the oldest expectation and compares it against the completing cycle.
  task automatic sb_compare();
    exp_t e;
    e = sb_q.pop_front();
    checks++;
    if (apb.PRDATA !== e.prdata) begin
      errors++; $display("FAIL %s prdata: got %02h expected %02h", e.name, apb.PRDATA, e.prdata);
    end
    checks++;
    if (W_ENA !== e.w_ena || R_ENA !== e.r_ena) begin
      errors++; $display("FAIL %s strobes: got W_ENA=%b R_ENA=%b expected %b %b",
                         e.name, W_ENA, R_ENA, e.w_ena, e.r_ena);
    end
    checks++;
    if (APB_TX !== e.tx) begin
      errors++; $display("FAIL %s apb_tx: got %02h expected %02h", e.name, APB_TX, e.tx);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (apb.PREADY !== 1'b0 || W_ENA !== 1'b0 || R_ENA !== 1'b0 ||
        apb.PRDATA !== 8'h00 || APB_TX !== tx_hold) begin
      errors++;
      $display("FAIL %s idle: got PREADY=%b W_ENA=%b R_ENA=%b PRDATA=%02h APB_TX=%02h expected 0 0 0 00 %02h",
               name, apb.PREADY, W_ENA, R_ENA, apb.PRDATA, APB_TX, tx_hold);
    end
  endtask

  // One complete APB transfer with idle cycle after; FIFO inputs stay constant throughout.
  task automatic do_xfer(input string name, input logic wr,
                         input logic [7:0] addr, input logic [7:0] wdata);
    exp_t e;
    bit   done;
    e = predict(name, wr, addr, wdata);
    sb_q.push_back(e);
    @(posedge clk); #1;
    apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr; apb.PADDR = addr; apb.PWDATA = wdata;
    @(negedge clk);
    checks++;
    if (apb.PREADY !== 1'b0 || W_ENA !== 1'b0 || R_ENA !== 1'b0) begin
      errors++; $display("FAIL %s setup: got PREADY=%b W_ENA=%b R_ENA=%b expected 0 0 0",
                         name, apb.PREADY, W_ENA, R_ENA);
    end
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 8 && !done; n++) begin
      @(negedge clk);
      if (apb.PREADY === 1'b1) done = 1'b1;
    end
    if (done) begin
      sb_compare();
      model_commit(wr, addr, wdata, e.w_ena);
    end else begin
      void'(sb_q.pop_front());
      checks++; errors++;
      $display("FAIL %s timeout: PREADY stayed %b, expected 1 within 8 cycles", name, apb.PREADY);
    end
    @(posedge clk); #1;
    apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
    @(negedge clk);
    check_idle(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    APB_RX = 8'hA3; WRITE_FULL = 1'b1; READ_EMPTY = 1'b0;
    apb.PSELx = 1'b1; apb.PENABLE = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = 8'h00; apb.PWDATA = 8'hFF;
    m_ctrl = 8'h00; m_saddr = 8'h00; m_presc = 8'h00; tx_hold = 8'h00;
    repeat (3) @(negedge clk);
    check_idle("reset");
    apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    WRITE_FULL = 1'b0;
    do_xfer("reset_ctrl", 1'b0, 8'h02, 8'h00);
    do_xfer("reset_saddr", 1'b0, 8'h03, 8'h00);
    do_xfer("reset_presc", 1'b0, 8'h04, 8'h00);
  endtask

  task automatic test_data_write();
    WRITE_FULL = 1'b0;
    do_xfer("data_write_55", 1'b1, 8'h00, 8'h55);
    do_xfer("data_write_aa", 1'b1, 8'h00, 8'hAA);
  endtask

  task automatic test_data_read();
    READ_EMPTY = 1'b0;
    APB_RX = 8'hA3;
    do_xfer("data_read_a3", 1'b0, 8'h00, 8'h00);
    APB_RX = 8'h5C;
    do_xfer("data_read_5c", 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_reg_rw();
    do_xfer("saddr_write", 1'b1, 8'h03, 8'h7E);
    do_xfer("saddr_read", 1'b0, 8'h03, 8'h00);
    do_xfer("ctrl_write", 1'b1, 8'h02, 8'hC1);
    do_xfer("presc_write", 1'b1, 8'h04, 8'h19);
    do_xfer("ctrl_read", 1'b0, 8'h02, 8'h00);
    do_xfer("presc_read", 1'b0, 8'h04, 8'h00);
    do_xfer("unmapped_write", 1'b1, 8'h09, 8'h33);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] a, d;
      a = 8'($urandom_range(2, 4));
      d = 8'($urandom);
      do_xfer("rand_write", 1'b1, a, d);
      do_xfer("rand_read", 1'b0, a, 8'h00);
    end
  endtask

  task automatic test_status();
    WRITE_FULL = 1'b1; READ_EMPTY = 1'b1;
    do_xfer("status_11", 1'b0, 8'h01, 8'h00);
    do_xfer("unmapped_read", 1'b0, 8'h09, 8'h00);
    WRITE_FULL = 1'b0; READ_EMPTY = 1'b1;
    do_xfer("status_10", 1'b0, 8'h01, 8'h00);
    WRITE_FULL = 1'b1; READ_EMPTY = 1'b0;
    do_xfer("status_01", 1'b0, 8'h01, 8'h00);
    WRITE_FULL = 1'b0; READ_EMPTY = 1'b0;
  endtask

  task automatic test_blocked();
`ifdef APB_WAIT_STATE_EN
    exp_t e;
    // Stalled write: two wait cycles, then WRITE_FULL drops and the push completes.
    WRITE_FULL = 1'b1;
    sb_q.push_back('{name: "stall_write", prdata: 8'h00, w_ena: 1'b1, r_ena: 1'b0, tx: 8'h5A});
    @(posedge clk); #1;
    apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 8'h00; apb.PWDATA = 8'h5A;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checks++;
      if (apb.PREADY !== 1'b0 || W_ENA !== 1'b0) begin
        errors++; $display("FAIL stall_write wait: got PREADY=%b W_ENA=%b expected 0 0", apb.PREADY, W_ENA);
      end
      @(posedge clk); #1;
    end
    WRITE_FULL = 1'b0;
    @(negedge clk);
    checks++;
    if (apb.PREADY !== 1'b1) begin
      errors++; $display("FAIL stall_write ready: got PREADY=%b expected 1", apb.PREADY);
    end
    sb_compare();
    tx_hold = 8'h5A;
    @(posedge clk); #1;
    apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
    @(negedge clk);
    check_idle("stall_write");
    // Stalled read: pops only once READ_EMPTY clears.
    READ_EMPTY = 1'b1; APB_RX = 8'h3C;
    sb_q.push_back('{name: "stall_read", prdata: 8'h3C, w_ena: 1'b0, r_ena: 1'b1, tx: 8'h5A});
    @(posedge clk); #1;
    apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 8'h00;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checks++;
      if (apb.PREADY !== 1'b0 || R_ENA !== 1'b0 || apb.PRDATA !== 8'h00) begin
        errors++; $display("FAIL stall_read wait: got PREADY=%b R_ENA=%b PRDATA=%02h expected 0 0 00",
                           apb.PREADY, R_ENA, apb.PRDATA);
      end
      @(posedge clk); #1;
    end
    READ_EMPTY = 1'b0;
    @(negedge clk);
    checks++;
    if (apb.PREADY !== 1'b1) begin
      errors++; $display("FAIL stall_read ready: got PREADY=%b expected 1", apb.PREADY);
    end
    sb_compare();
    @(posedge clk); #1;
    apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
    @(negedge clk);
    check_idle("stall_read");
    e = predict("after_stall", 1'b0, 8'h01, 8'h00);
    void'(e);
`else
    WRITE_FULL = 1'b1;
    do_xfer("dropped_write", 1'b1, 8'h00, 8'h5A);
    WRITE_FULL = 1'b0;
    READ_EMPTY = 1'b1; APB_RX = 8'h3C;
    do_xfer("empty_read", 1'b0, 8'h00, 8'h00);
    READ_EMPTY = 1'b0;
`endif
  endtask

  task automatic test_penable_no_setup();
    @(posedge clk); #1;
    apb.PSELx = 1'b1; apb.PENABLE = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = 8'h00; apb.PWDATA = 8'h99;
    repeat (2) begin
      @(negedge clk);
      check_idle("penable_no_setup");
    end
    @(posedge clk); #1;
    apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic test_back_to_back();
    sb_q.push_back(predict("b2b_write", 1'b1, 8'h00, 8'h11));
    @(posedge clk); #1;
    apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 8'h00; apb.PWDATA = 8'h11;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    @(negedge clk);
    checks++;
    if (apb.PREADY !== 1'b1) begin
      errors++; $display("FAIL b2b_write ready: got PREADY=%b expected 1", apb.PREADY);
    end
    sb_compare();
    tx_hold = 8'h11;
    sb_q.push_back(predict("b2b_read", 1'b0, 8'h03, 8'h00));
    @(posedge clk); #1;
    apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 8'h03;
    @(negedge clk);
    check_idle("b2b_setup");
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    @(negedge clk);
    checks++;
    if (apb.PREADY !== 1'b1) begin
      errors++; $display("FAIL b2b_read ready: got PREADY=%b expected 1", apb.PREADY);
    end
    sb_compare();
    @(posedge clk); #1;
    apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
    @(negedge clk);
    check_idle("b2b_end");
  endtask

  task automatic test_reset_abort();
    WRITE_FULL = 1'b0;
    @(posedge clk); #1;
    apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 8'h00; apb.PWDATA = 8'hEE;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    rst_n = 1'b0;
    m_ctrl = 8'h00; m_saddr = 8'h00; m_presc = 8'h00; tx_hold = 8'h00;
    @(negedge clk);
    check_idle("reset_abort");
    @(posedge clk); #1;
    apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_xfer("abort_saddr", 1'b0, 8'h03, 8'h00);
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_data_read();
    test_reg_rw();
    test_status();
    test_blocked();
    test_penable_no_setup();
    test_back_to_back();
    test_reset_abort();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
